dm_write_buffer: RTL and testbench

Posted-write buffer between the CPU data-memory port and the backing data SRAM. Stores (`DM_enable` high) are captured into a small FIFO and retire to the SRAM's write port over a req/ack handshake, so a slow write port never lengthens the CPU cycle. Loads read the SRAM combinationally; with forwarding compiled in, they are served from the buffer when a pending store targets the same word. The CPU stalls only when the buffer is full, or, without forwarding, on a hazard.

---
 rtl/dm_wb_pkg.sv | 20 ++
 rtl/dm_wb_fifo.sv | 72 +++++++
 rtl/dm_write_buffer.sv | 100 ++++++++++
 tb/tb_dm_write_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_wb_pkg.sv
// Shared sizing, entry layout and pointer-width helper for the data-memory
// posted-write buffer.
package dm_wb_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned MEM_SIZE  = 16;
  localparam int unsigned DEPTH     = 4;

  // Packed layout of one buffered store: address in the upper bits, data below.
  typedef struct packed {
    logic [MEM_SIZE-1:0]  addr;
    logic [DATA_SIZE-1:0] data;
  } dm_wb_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/dm_wb_fifo.sv
// Circular FIFO holding pending stores. Also exposes an age-ordered view of
// all slots (index 0 = oldest) with a matching per-slot valid vector.
module dm_wb_fifo
  import dm_wb_pkg::*;
#(
  parameter int unsigned ew    = MEM_SIZE + DATA_SIZE,
  parameter int unsigned depth = DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [ew-1:0]             push_entry_i,
  input  logic                      pop_i,
  output logic [ew-1:0]             head_entry_o,
  output logic [ptr_width(depth):0] count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [depth-1:0]          valid_o,
  output logic [depth*ew-1:0]       entries_o
);

  localparam int unsigned PW = ptr_width(depth);
  localparam int unsigned CW = PW + 1;

  logic [ew-1:0] mem_q [depth];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;
  assign full_o       = (count_q == CW'(depth));
  assign empty_o      = (count_q == '0);

  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_view
      assign entries_o[gi*ew +: ew] = mem_q[head_q + PW'(gi)];
      assign valid_o[gi]            = (count_q > CW'(gi));
    end
  endgenerate

endmodule

// File: rtl/dm_write_buffer.sv
// Posted-write buffer between the CPU data port and the data SRAM write port.
// Define DM_WB_FWD_EN to forward loads from pending stores instead of stalling.
module dm_write_buffer
  import dm_wb_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned mem_size  = MEM_SIZE,
  parameter int unsigned depth     = DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [mem_size-1:0]  DM_Address,
  input  logic                 DM_enable,
  input  logic [data_size-1:0] DM_Write_Data,
  output logic [data_size-1:0] DM_Read_Data,
  output logic                 cpu_stall,
  output logic [mem_size-1:0]  mem_rd_addr,
  input  logic [data_size-1:0] mem_rd_data,
  output logic                 mem_wr_req,
  output logic [mem_size-1:0]  mem_wr_addr,
  output logic [data_size-1:0] mem_wr_data,
  input  logic                 mem_wr_ack,
  output logic                 wb_busy
);

  localparam int unsigned EW = mem_size + data_size;
  localparam int unsigned CW = ptr_width(depth) + 1;

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [EW-1:0]       head_entry;
  logic [CW-1:0]       count;
  logic [depth-1:0]    valid;
  logic [depth-1:0]    addr_hit;
  logic [depth*EW-1:0] entry_view;

  // Stall never depends on ack, so a same-cycle drain cannot admit a store into a full buffer.
  assign push = DM_enable && !cpu_stall;
  assign pop  = mem_wr_req && mem_wr_ack;

  dm_wb_fifo #(
    .ew    (EW),
    .depth (depth)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i ({DM_Address, DM_Write_Data}),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .valid_o      (valid),
    .entries_o    (entry_view)
  );

  assign mem_wr_req  = !empty;
  assign wb_busy     = (count != '0);
  assign mem_wr_addr = head_entry[EW-1 -: mem_size];
  assign mem_wr_data = head_entry[data_size-1:0];
  assign mem_rd_addr = DM_Address;

  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_match
      assign addr_hit[gi] = valid[gi] &&
                            (entry_view[gi*EW + data_size +: mem_size] == DM_Address);
    end
  endgenerate

`ifdef DM_WB_FWD_EN
  logic                 fwd_hit;
  logic [data_size-1:0] fwd_data;

  // Scan oldest to youngest so the last hit is the most recent store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < depth; k++) begin
      if (addr_hit[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_view[k*EW +: data_size];
      end
    end
  end

  assign DM_Read_Data = fwd_hit ? fwd_data : mem_rd_data;
  assign cpu_stall    = DM_enable && full;
`else
  logic unused_view_data;
  assign unused_view_data = ^entry_view;

  // A load that hits a pending store waits until that store has reached the SRAM.
  assign DM_Read_Data = mem_rd_data;
  assign cpu_stall    = DM_enable ? full : (|addr_hit);
`endif

endmodule

// File: tb/tb_dm_write_buffer.sv
// Directed bench for dm_write_buffer with a write-order scoreboard on the SRAM port.
module tb_dm_write_buffer;
  import dm_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DM_Address;
  logic        DM_enable;
  logic [31:0] DM_Write_Data;
  logic [31:0] DM_Read_Data;
  logic        cpu_stall;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [15:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        wb_busy;

  int checks   = 0;
  int failures = 0;
  dm_wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign mem_rd_data = rd_fn(mem_rd_addr);

  dm_write_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .DM_Address    (DM_Address),
    .DM_enable     (DM_enable),
    .DM_Write_Data (DM_Write_Data),
    .DM_Read_Data  (DM_Read_Data),
    .cpu_stall     (cpu_stall),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .mem_wr_req    (mem_wr_req),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ack    (mem_wr_ack),
    .wb_busy       (wb_busy)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every SRAM write (req && ack seen before the edge) must match the oldest expected store.
  always @(negedge clk) begin : mon
    dm_wb_entry_t e;
    if (rst && mem_wr_req && mem_wr_ack) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 'x;
      $display("sram write addr=%h data=%h expected addr=%h data=%h",
               mem_wr_addr, mem_wr_data, e.addr, e.data);
      chk_val("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
      chk_val("wr_data", 64'(mem_wr_data), 64'(e.data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d, input string tag);
    DM_enable     = 1'b1;
    DM_Address    = a;
    DM_Write_Data = d;
    @(negedge clk);
    chk_bit(tag, cpu_stall, 1'b0);
    exp_q.push_back('{addr: a, data: d});
    step();
    DM_enable = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    step();
    mem_wr_ack = 1'b1;
    @(negedge clk);
    while (wb_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_bit({tag, "_drained"}, wb_busy, 1'b0);
    chk_val({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    step();
    mem_wr_ack = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    DM_enable     = 1'b0;
    DM_Address    = 16'h1234;
    DM_Write_Data = '0;
    mem_wr_ack    = 1'b0;

    // Reset state
    @(negedge clk);
    chk_bit("rst_req", mem_wr_req, 1'b0);
    chk_bit("rst_busy", wb_busy, 1'b0);
    chk_bit("rst_stall", cpu_stall, 1'b0);
    chk_val("rst_rd", 64'(DM_Read_Data), 64'(rd_fn(16'h1234)));
    step();
    rst = 1'b1;
    step();

    // Basic store with ack tied high
    mem_wr_ack = 1'b1;
    store(16'h0010, 32'hDEADBEEF, "t1_accept");
    @(negedge clk);
    chk_bit("t1_req", mem_wr_req, 1'b1);
    chk_val("t1_addr", 64'(mem_wr_addr), 64'h0010);
    chk_val("t1_data", 64'(mem_wr_data), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk_bit("t1_req_low", mem_wr_req, 1'b0);
    chk_bit("t1_busy_low", wb_busy, 1'b0);
    step();
    mem_wr_ack = 1'b0;

    // Fill to full, then a fifth store waits for exactly one ack
    for (int i = 1; i <= 4; i++) store(16'(i), 32'h100 + 32'(i), "t2_accept");
    DM_enable     = 1'b1;
    DM_Address    = 16'h0005;
    DM_Write_Data = 32'h105;
    @(negedge clk);
    chk_bit("t2_full_stall", cpu_stall, 1'b1);
    chk_val("t2_head_addr", 64'(mem_wr_addr), 64'h0001);
    step();
    mem_wr_ack = 1'b1;
    @(negedge clk);
    chk_bit("t2_stall_with_ack", cpu_stall, 1'b1);
    step();
    mem_wr_ack = 1'b0;
    @(negedge clk);
    chk_bit("t2_retry_accept", cpu_stall, 1'b0);
    exp_q.push_back('{addr: 16'h0005, data: 32'h105});
    step();
    DM_enable = 1'b0;
    drain("t2");

    // Two stores to one address, then a load of it
    store(16'h0020, 32'hA, "t3_a");
    store(16'h0020, 32'hB, "t3_b");
    DM_Address = 16'h0020;
    @(negedge clk);
`ifdef DM_WB_FWD_EN
    chk_val("t3_fwd_youngest", 64'(DM_Read_Data), 64'hB);
    chk_bit("t3_no_stall", cpu_stall, 1'b0);
`else
    chk_bit("t3_hazard_stall", cpu_stall, 1'b1);
    chk_val("t3_rd_sram", 64'(DM_Read_Data), 64'(rd_fn(16'h0020)));
    step();
    mem_wr_ack = 1'b1;
    @(negedge clk);
    chk_bit("t3_stall_one_left", cpu_stall, 1'b1);
`endif
    drain("t3");
    @(negedge clk);
    chk_bit("t3_stall_clear", cpu_stall, 1'b0);
    chk_val("t3_rd_after", 64'(DM_Read_Data), 64'(rd_fn(16'h0020)));
    step();

    // Push and pop together at count 2, crossing the pointer wrap
    store(16'h0030, 32'h300, "t4_pre0");
    store(16'h0031, 32'h301, "t4_pre1");
    mem_wr_ack = 1'b1;
    for (int i = 2; i < 6; i++) store(16'h0030 + 16'(i), 32'h300 + 32'(i), "t4_pushpop");
    mem_wr_ack = 1'b0;
    store(16'h0036, 32'h306, "t4_fill0");
    store(16'h0037, 32'h307, "t4_fill1");
    DM_enable     = 1'b1;
    DM_Address    = 16'h0038;
    DM_Write_Data = 32'h308;
    @(negedge clk);
    chk_bit("t4_count_kept", cpu_stall, 1'b1);
    step();
    DM_enable = 1'b0;
    drain("t4");

    // Reset with three pending entries
    store(16'h0040, 32'h400, "t5_pre0");
    store(16'h0041, 32'h401, "t5_pre1");
    store(16'h0042, 32'h402, "t5_pre2");
    DM_Address = 16'h0041;
    @(negedge clk);
`ifdef DM_WB_FWD_EN
    chk_bit("t5_pre_stall", cpu_stall, 1'b0);
`else
    chk_bit("t5_pre_stall", cpu_stall, 1'b1);
`endif
    chk_bit("t5_pre_busy", wb_busy, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk_bit("t5_rst_req", mem_wr_req, 1'b0);
    chk_bit("t5_rst_busy", wb_busy, 1'b0);
    chk_bit("t5_rst_stall", cpu_stall, 1'b0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step();
    mem_wr_ack = 1'b1;
    store(16'h0050, 32'h12345678, "t5_post");
    drain("t5");

    // Loads with three stores pending
    store(16'h0060, 32'h600, "t6_pre0");
    store(16'h0061, 32'h601, "t6_pre1");
    store(16'h0062, 32'h602, "t6_pre2");
    DM_Address = 16'h0099;
    @(negedge clk);
    chk_val("t6_miss_rd", 64'(DM_Read_Data), 64'(rd_fn(16'h0099)));
    chk_bit("t6_miss_stall", cpu_stall, 1'b0);
    DM_Address = 16'h0061;
    #1;
`ifdef DM_WB_FWD_EN
    chk_val("t6_hit_rd", 64'(DM_Read_Data), 64'h601);
`else
    chk_bit("t6_hit_stall", cpu_stall, 1'b1);
`endif
    DM_Address = 16'h0099;
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
